// File: rtl/act_c2_share_arb.sv
// Round-robin arbiter that time-shares one external ACT C2 mux cell among four
// requesters: latch the winner's operands, capture the cell result, hold it until accepted.
module act_c2_share_arb #(
  parameter int BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [16*BITS-1:0]   req_d,
  input  logic [15:0]          req_sel,
  output logic [3:0]           gnt,
  output logic [4*BITS-1:0]    cell_d,
  output logic [3:0]           cell_sel,
  input  logic [BITS-1:0]      cell_out,
  output logic                 res_valid,
  output logic [BITS-1:0]      res_data,
  output logic [1:0]           res_id,
  input  logic                 res_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [3:0]          gnt_q, gnt_d;
  logic [4*BITS-1:0]   cell_d_q, cell_d_d;
  logic [3:0]          cell_sel_q, cell_sel_d;
  logic                res_valid_q, res_valid_d;
  logic [BITS-1:0]     res_data_q, res_data_d;
  logic [1:0]          res_id_q, res_id_d;
  logic                busy_q, busy_d;

  logic [1:0]          win;
  logic [1:0]          cand;
  logic                found;

  // Rotating priority: scan from the farthest candidate back so ptr itself wins last-assigned.
  always_comb begin
    win   = ptr_q;
    cand  = ptr_q;
    found = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = 4'b0000;
    cell_d_d    = cell_d_q;
    cell_sel_d  = cell_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d      = 4'b0001 << win;
          cell_d_d   = req_d[int'(win)*4*BITS +: 4*BITS];
          cell_sel_d = req_sel[int'(win)*4 +: 4];
          res_id_d   = win;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // The cell is purely combinational on the latched operands; its output is taken as-is.
        res_data_d  = cell_out;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          ptr_d       = res_id_q + 2'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      gnt_q       <= 4'b0000;
      cell_d_q    <= '0;
      cell_sel_q  <= 4'b0000;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 2'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cell_d_q    <= cell_d_d;
      cell_sel_q  <= cell_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign gnt       = gnt_q;
  assign cell_d    = cell_d_q;
  assign cell_sel  = cell_sel_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule

// File: doc/act_c2_share_arb.md
ACT_C2_SHARE_ARB -- requirements
Module: act_c2_share_arb

Interface
REQ-001 The block SHALL have parameter BITS, default 8, giving the data width of each mux data input and of the result.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request, level, held until granted.
REQ-005 The block SHALL have port req_d, input, 16*BITS bits: requester i in slice [i*4*BITS +: 4*BITS], ordered {D11,D10,D01,D00} with D00 lowest.
REQ-006 The block SHALL have port req_sel, input, 16 bits: requester i in slice [i*4 +: 4], ordered {A1,B1,A0,B0}.
REQ-007 The block SHALL have port gnt, output, 4 bits: one-hot grant pulse.
REQ-008 The block SHALL have port cell_d, output, 4*BITS bits: drives the shared C2 cell data inputs, same packing as one req_d slice.
REQ-009 The block SHALL have port cell_sel, output, 4 bits: drives the shared cell {A1,B1,A0,B0}.
REQ-010 The block SHALL have port cell_out, input, BITS bits: combinational result of the shared cell.
REQ-011 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-012 The block SHALL have port res_data, output, BITS bits: captured result.
REQ-013 The block SHALL have port res_id, output, 2 bits: index of the requester owning res_data.
REQ-014 The block SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RESP; all outputs SHALL be registered.
REQ-017 In IDLE with req!=0, the winner SHALL be the first asserted requester searching ptr, ptr+1, ... mod 4.
REQ-018 In IDLE with req!=0, on the same edge the block SHALL latch the winner's req_d/req_sel slices into cell_d/cell_sel, set gnt to one-hot(winner) and res_id to winner, and enter ISSUE.
REQ-019 In IDLE with req==0, the block SHALL remain in IDLE with gnt=0.
REQ-020 gnt SHALL be high only during the single ISSUE cycle.
REQ-021 In ISSUE, the block SHALL capture cell_out into res_data on the next edge, set res_valid=1, clear gnt and enter RESP.
REQ-022 In RESP, res_valid, res_data, res_id, cell_d and cell_sel SHALL hold stable while res_ready=0.
REQ-023 In RESP with res_ready=1, the block SHALL clear res_valid, set ptr=(res_id+1) mod 4 and return to IDLE.
REQ-024 Latency from req sampled in IDLE to res_valid SHALL be 2 cycles; peak throughput SHALL be one operation per 3 cycles.
REQ-025 cell_d and cell_sel SHALL keep their last latched values outside ISSUE; they SHALL change only on an IDLE->ISSUE transition.
REQ-026 Requests SHALL be sampled only in IDLE; req changes in ISSUE or RESP SHALL have no effect.
REQ-027 A granted requester that keeps req high SHALL be served again only after every other asserted requester has been served once.
REQ-028 An X or Z value on cell_out SHALL be captured unmodified; the block SHALL perform no checking of it.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL enter IDLE and set ptr=0, gnt=0, res_valid=0, res_data=0, res_id=0, cell_d=0, cell_sel=0 and busy=0.
REQ-030 Reset SHALL take priority in any state; an in-flight operation SHALL be discarded and produce no result.

Verification
REQ-031 Hold rst_n=0 for 2 cycles -> all outputs 0 and busy=0.
REQ-032 Single request: req=0001, D00=11h, D01=22h, D10=33h, D11=44h, sel{A1,B1,A0,B0}=0111 -> gnt=0001 at cycle+1; res_valid at cycle+2 with res_data=44h, res_id=0.
REQ-033 Mux cases, requester 2, same data: sel=0000 -> 11h; 0010 -> 11h (A0&B0=0); 0011 -> 22h; 1000 -> 33h.
REQ-034 req=1111 held continuously, res_ready=1 -> res_id sequence 0,1,2,3,0 with one result every 3 cycles.
REQ-035 Backpressure: res_ready=0 for 5 cycles in RESP -> res_valid, res_data and res_id stable and gnt=0 throughout; IDLE one cycle after res_ready=1.
REQ-036 Reset mid-operation: rst_n=0 during ISSUE -> next cycle all outputs 0, no result is produced, and the next grant starts the search from requester 0.
